// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - line-granular write-back buffer between the cache memory port and physical memory
//
// Absorbs evicted dirty lines into a small FIFO, acknowledges them quickly and
// drains them to memory whenever the upstream side is idle. Reads that hit a
// buffered line are served from the buffer; misses go to physical memory.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   c_read, c_write             upstream line read / write, held until c_resp
//   c_address, c_wdata          upstream line address and write data
//   c_resp, c_rdata             one-cycle completion pulse and read line
//   pmem_read, pmem_write       requests to physical memory
//   pmem_address, pmem_wdata    line-aligned memory address and write line
//   pmem_resp, pmem_rdata       memory completion and read line
//   wb_count                    number of occupied buffer entries

module writeback_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    c_read,
  input  logic                    c_write,
  input  logic [ADDR_WIDTH-1:0]   c_address,
  input  logic [LINE_WIDTH-1:0]   c_wdata,
  output logic                    c_resp,
  output logic [LINE_WIDTH-1:0]   c_rdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [LINE_WIDTH-1:0]   pmem_wdata,
  input  logic                    pmem_resp,
  input  logic [LINE_WIDTH-1:0]   pmem_rdata,
  output logic [$clog2(DEPTH):0]  wb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_MEM_READ,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]      tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_WIDTH-1:0] rdata_q;

  logic [TAG_W-1:0]      c_tag;
  logic [DEPTH-1:0]      entry_valid;
  logic                  hit;
  logic [PTR_W-1:0]      hit_idx;
  logic                  full;

  logic do_push, do_coal, do_pop, ld_hit, ld_miss, ld_mem;

  // The byte offset inside a line never affects matching or memory addresses.
  logic unused_offset_bits;
  assign unused_offset_bits = ^c_address[3:0];

  assign c_tag = c_address[ADDR_WIDTH-1:4];
  assign full  = (count == CNT_W'(DEPTH));

  // An entry is occupied when its distance from head (modulo DEPTH) is below
  // the count, so no separate valid bits need to be kept or cleared.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(i) - head} < count);
    end
  end

  // At most one entry holds a given line, so the last match is the only match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (tag_q[i] == c_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    do_push   = 1'b0;
    do_coal   = 1'b0;
    do_pop    = 1'b0;
    ld_hit    = 1'b0;
    ld_miss   = 1'b0;
    ld_mem    = 1'b0;
    case (state)
      S_IDLE: begin
        if (c_read) begin
          if (hit) begin
            ld_hit    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            ld_miss   = 1'b1;
            state_nxt = S_MEM_READ;
          end
        end else if (c_write) begin
          if (hit) begin
            do_coal   = 1'b1;
            state_nxt = S_RESP;
          end else if (!full) begin
            do_push   = 1'b1;
            state_nxt = S_RESP;
          end else begin
            // Make room first; the write is looked at again back in IDLE.
            state_nxt = S_DRAIN;
          end
        end else if (count != '0) begin
          state_nxt = S_DRAIN;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      S_MEM_READ: begin
        if (pmem_resp) begin
          ld_mem    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_DRAIN: begin
        if (pmem_resp) begin
          do_pop    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rd_tag  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (do_push) begin
        tail  <= tail + PTR_W'(1);
        count <= count + CNT_W'(1);
      end
      if (do_pop) begin
        head  <= head + PTR_W'(1);
        count <= count - CNT_W'(1);
      end
      if (ld_hit) begin
        rdata_q <= data_q[hit_idx];
      end else if (ld_mem) begin
        rdata_q <= pmem_rdata;
      end
      if (ld_miss) begin
        rd_tag <= c_tag;
      end
    end
  end

  // Line storage carries no reset: occupancy is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_q[tail]  <= c_tag;
      data_q[tail] <= c_wdata;
    end else if (do_coal) begin
      data_q[hit_idx] <= c_wdata;
    end
  end

  always_comb begin
    c_resp       = (state == S_RESP);
    c_rdata      = rdata_q;
    pmem_read    = (state == S_MEM_READ);
    pmem_write   = (state == S_DRAIN);
    pmem_address = '0;
    pmem_wdata   = '0;
    wb_count     = count;
    if (state == S_MEM_READ) begin
      pmem_address = {rd_tag, 4'b0000};
    end else if (state == S_DRAIN) begin
      pmem_address = {tag_q[head], 4'b0000};
      pmem_wdata   = data_q[head];
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - self-checking bench for writeback_buffer against a queue-based reference model

module tb_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int ACT_NONE  = 0;
  localparam int ACT_RESP  = 1;
  localparam int ACT_FETCH = 2;
  localparam int ACT_FLUSH = 3;

  localparam logic [127:0] LINE_A = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] LINE_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] LINE_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] LINE_D = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
  localparam logic [127:0] LINE_E = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         c_read = 1'b0;
  logic         c_write = 1'b0;
  logic [15:0]  c_address = '0;
  logic [127:0] c_wdata = '0;
  logic         c_resp;
  logic [127:0] c_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [127:0] pmem_rdata = '0;
  logic [2:0]   wb_count;

  always #5 clk = ~clk;

  writeback_buffer #(
    .DEPTH(DEPTH),
    .ADDR_WIDTH(16),
    .LINE_WIDTH(128)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .c_read(c_read),
    .c_write(c_write),
    .c_address(c_address),
    .c_wdata(c_wdata),
    .c_resp(c_resp),
    .c_rdata(c_rdata),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata),
    .wb_count(wb_count)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Backing memory and the latest data written by upstream for each line.
  logic [127:0] mem  [logic [11:0]];
  logic [127:0] gold [logic [11:0]];

  function automatic logic [127:0] mem_get(input logic [11:0] t);
    if (mem.exists(t)) return mem[t];
    return {8{t, 4'hA}};
  endfunction

  function automatic logic [127:0] gold_get(input logic [11:0] t);
    if (gold.exists(t)) return gold[t];
    return {8{t, 4'hA}};
  endfunction

  // Reference model: buffered lines are an ordered queue, oldest first.
  typedef struct {
    logic [11:0]  tag;
    logic [127:0] data;
  } ent_t;

  ent_t         m_q[$];
  ent_t         m_ent;
  int           m_act = ACT_NONE;
  int           m_idx;
  logic [11:0]  m_tag;
  logic [11:0]  m_fetch_tag = '0;
  logic [127:0] m_rdata = '0;

  function automatic int m_find(input logic [11:0] t);
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i].tag == t) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_exp_addr();
    if (m_act == ACT_FETCH) return {m_fetch_tag, 4'h0};
    if (m_act == ACT_FLUSH && m_q.size() > 0) return {m_q[0].tag, 4'h0};
    return 16'h0000;
  endfunction

  function automatic logic [127:0] m_exp_wdata();
    if (m_act == ACT_FLUSH && m_q.size() > 0) return m_q[0].data;
    return '0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_act       = ACT_NONE;
      m_rdata     = '0;
      m_fetch_tag = '0;
    end else begin
      m_tag = c_address[15:4];
      case (m_act)
        ACT_NONE: begin
          m_idx = m_find(m_tag);
          if (c_read) begin
            if (m_idx >= 0) begin
              m_rdata = m_q[m_idx].data;
              m_act   = ACT_RESP;
            end else begin
              m_fetch_tag = m_tag;
              m_act       = ACT_FETCH;
            end
          end else if (c_write) begin
            if (m_idx >= 0) begin
              m_ent      = m_q[m_idx];
              m_ent.data = c_wdata;
              m_q[m_idx] = m_ent;
              m_act      = ACT_RESP;
            end else if (m_q.size() < DEPTH) begin
              m_ent.tag  = m_tag;
              m_ent.data = c_wdata;
              m_q.push_back(m_ent);
              m_act = ACT_RESP;
            end else begin
              m_act = ACT_FLUSH;
            end
          end else if (m_q.size() > 0) begin
            m_act = ACT_FLUSH;
          end
        end
        ACT_RESP: m_act = ACT_NONE;
        ACT_FETCH: begin
          if (pmem_resp) begin
            m_rdata = pmem_rdata;
            m_act   = ACT_RESP;
          end
        end
        ACT_FLUSH: begin
          if (pmem_resp) begin
            void'(m_q.pop_front());
            m_act = ACT_NONE;
          end
        end
        default: m_act = ACT_NONE;
      endcase
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("c_resp", 128'(c_resp), 128'(m_act == ACT_RESP));
      check("c_rdata", c_rdata, m_rdata);
      check("pmem_read", 128'(pmem_read), 128'(m_act == ACT_FETCH));
      check("pmem_write", 128'(pmem_write), 128'(m_act == ACT_FLUSH));
      check("pmem_address", 128'(pmem_address), 128'(m_exp_addr()));
      check("pmem_wdata", pmem_wdata, m_exp_wdata());
      check("wb_count", 128'(wb_count), 128'(m_q.size()));
    end
  end

  // Memory responder: answers each request after a delay unless stalled.
  bit  mem_stall = 1'b0;
  int  mem_delay = -1;
  int  mem_age = 0;
  int  mem_cur_delay = 0;

  initial forever begin
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (!rst_n || !(pmem_read || pmem_write)) begin
      mem_age       = 0;
      mem_cur_delay = (mem_delay < 0) ? int'($urandom_range(0, 5)) : mem_delay;
    end else begin
      if (!mem_stall && mem_age >= mem_cur_delay) begin
        pmem_resp = 1'b1;
        if (pmem_read) pmem_rdata = mem_get(pmem_address[15:4]);
        else mem[pmem_address[15:4]] = pmem_wdata;
      end
      mem_age++;
    end
  end

  bit          saw_rd = 1'b0;
  logic [15:0] last_rd_addr = '0;

  initial forever begin
    @(negedge clk);
    if (pmem_read) begin
      saw_rd       = 1'b1;
      last_rd_addr = pmem_address;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Presents one request (called just after a rising edge), waits for c_resp,
  // then drops the request on the following edge.
  task automatic do_req(input bit rd, input logic [15:0] a, input logic [127:0] d,
                        output logic [127:0] rdata, output int lat);
    c_read    = rd;
    c_write   = !rd;
    c_address = a;
    c_wdata   = d;
    lat       = 0;
    while (c_resp !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (c_resp !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: c_resp=%b for addr %h after %0d cycles, required 1", c_resp, a, lat);
    end
    rdata = c_rdata;
    if (!rd) gold[a[15:4]] = d;
    @(posedge clk);
    #1;
    c_read  = 1'b0;
    c_write = 1'b0;
  endtask

  task automatic wait_pmem_write();
    int n = 0;
    while (!pmem_write && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pmem_write) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_start: pmem_write=%b after %0d cycles, required 1", pmem_write, n);
    end
  endtask

  task automatic drain_all();
    int n = 0;
    while ((wb_count != 0 || pmem_write || c_resp) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (wb_count != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_all: wb_count=%0d after %0d cycles, required 0", wb_count, n);
    end
  endtask

  logic [127:0] rdv;
  int           lat;
  int           gap;
  bit           r_rd;
  logic [11:0]  r_tag;
  logic [15:0]  r_addr;
  logic [127:0] r_data;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_c_resp", 128'(c_resp), 128'(0));
    check("rst_c_rdata", c_rdata, 128'(0));
    check("rst_pmem_read", 128'(pmem_read), 128'(0));
    check("rst_pmem_write", 128'(pmem_write), 128'(0));
    check("rst_pmem_address", 128'(pmem_address), 128'(0));
    check("rst_pmem_wdata", pmem_wdata, 128'(0));
    check("rst_wb_count", 128'(wb_count), 128'(0));
    @(posedge clk);
    #1;

    // Write accept then drain: c_resp one cycle after the request is seen.
    do_req(1'b0, 16'h1230, LINE_A, rdv, lat);
    check("wr_latency", 128'(lat), 128'(1));
    wait_pmem_write();
    check("drain_addr_1230", 128'(pmem_address), 128'(16'h1230));
    check("drain_data_A", pmem_wdata, LINE_A);
    check("drain_count_1", 128'(wb_count), 128'(1));
    for (int n = 0; n < 200 && pmem_write; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_count_0", 128'(wb_count), 128'(0));
    check("mem_1230", mem_get(12'h123), LINE_A);

    // Read hit with memory held busy: served from the buffer.
    mem_stall = 1'b1;
    saw_rd    = 1'b0;
    do_req(1'b0, 16'h4000, LINE_B, rdv, lat);
    do_req(1'b1, 16'h4008, '0, rdv, lat);
    check("hit_data_B", rdv, LINE_B);
    check("hit_latency", 128'(lat), 128'(1));
    check("hit_no_pmem_read", 128'(saw_rd), 128'(0));
    mem_stall = 1'b0;
    drain_all();

    // Coalesce two writes to the same line.
    mem_stall = 1'b1;
    do_req(1'b0, 16'h2000, LINE_C, rdv, lat);
    do_req(1'b0, 16'h2004, LINE_D, rdv, lat);
    check("coal_count_1", 128'(wb_count), 128'(1));
    mem_stall = 1'b0;
    wait_pmem_write();
    check("coal_addr", 128'(pmem_address), 128'(16'h2000));
    check("coal_data_D", pmem_wdata, LINE_D);
    drain_all();

    // Full buffer: fifth distinct line waits for the oldest to drain.
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 16'(i * 16), {4{32'hF000_0000 + 32'(i)}}, rdv, lat);
    end
    check("full_count_4", 128'(wb_count), 128'(4));
    c_write   = 1'b1;
    c_address = 16'h0040;
    c_wdata   = {4{32'hF000_0004}};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("full_no_resp", 128'(c_resp), 128'(0));
    end
    check("full_drain_write", 128'(pmem_write), 128'(1));
    check("full_drain_addr", 128'(pmem_address), 128'(16'h0000));
    check("full_drain_data", pmem_wdata, {4{32'hF000_0000}});
    mem_stall = 1'b0;
    do_req(1'b0, 16'h0040, {4{32'hF000_0004}}, rdv, lat);
    check("full_after_count_4", 128'(wb_count), 128'(4));
    check("full_mem_0000", mem_get(12'h000), {4{32'hF000_0000}});
    drain_all();
    check("full_mem_0040", mem_get(12'h004), {4{32'hF000_0004}});

    // Read miss with a 5-cycle memory: 1 cycle to issue, 5 waiting, 1 to capture.
    mem[12'h800] = LINE_E;
    mem_delay    = 5;
    saw_rd       = 1'b0;
    do_req(1'b1, 16'h8000, '0, rdv, lat);
    check("miss_data_E", rdv, LINE_E);
    check("miss_latency", 128'(lat), 128'(7));
    check("miss_pmem_addr", 128'(last_rd_addr), 128'(16'h8000));
    check("miss_saw_read", 128'(saw_rd), 128'(1));
    mem_delay = -1;

    // Reset in the middle of a drain.
    mem_stall = 1'b1;
    do_req(1'b0, 16'h5550, LINE_A, rdv, lat);
    wait_pmem_write();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pmem_write", 128'(pmem_write), 128'(0));
    check("rst_mid_wb_count", 128'(wb_count), 128'(0));
    mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_c_resp", 128'(c_resp), 128'(0));
    check("rst_rel_c_rdata", c_rdata, 128'(0));
    check("rst_rel_pmem_write", 128'(pmem_write), 128'(0));
    check("rst_rel_pmem_read", 128'(pmem_read), 128'(0));
    check("rst_rel_pmem_address", 128'(pmem_address), 128'(0));
    check("rst_rel_wb_count", 128'(wb_count), 128'(0));
    @(posedge clk);
    #1;

    // Random traffic over a few lines so hits, coalescing and full cases occur.
    for (int k = 0; k < 300; k++) begin
      r_rd   = 1'($urandom_range(0, 1));
      r_tag  = 12'h100 + 12'($urandom_range(0, 5));
      r_addr = {r_tag, 4'($urandom_range(0, 15))};
      r_data = {$urandom, $urandom, $urandom, $urandom};
      do_req(r_rd, r_addr, r_data, rdv, lat);
      if (r_rd) check("rand_rd_data", rdv, gold_get(r_tag));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
    drain_all();
    for (int t = 0; t < 6; t++) begin
      check("rand_mem_final", mem_get(12'h100 + 12'(t)), gold_get(12'h100 + 12'(t)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
